hazard_seq: RTL and testbench

Sequencer and checker for two-input combinational hazard circuits. It drives the circuit inputs `a` and `b` through a fixed 8-step single-bit-change walk that covers every single-variable transition. Per step it records two things from a registered sample of the device output: hazards (extra output toggles) and static errors (wrong settled value against a reference output). It sits between a hazard-prone instance (`f_dut`) and a hazard-free or golden instance (`f_ref`) that share the same `a`/`b` inputs.

---
 rtl/hazard_seq_pkg.sv | 31 +++
 rtl/hazard_seq_toggle_counter.sv | 51 +++++
 rtl/hazard_seq.sv | 194 +++++++++++++++++++
 tb/tb_hazard_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_seq_pkg.sv
// Shared definitions for the hazard sequencer family.
//   - state_e      : sequencer FSM states
//   - Steps        : number of steps in one walk
//   - step_pattern : {a,b} applied during step k of the walk
package hazard_seq_pkg;

  localparam int unsigned Steps = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Single-bit-change walk starting and ending at 00. It covers a rising and
  // falling with b=0 and b=1, and b rising and falling with a=0 and a=1.
  function automatic logic [1:0] step_pattern(input logic [2:0] k);
    logic [1:0] p;
    unique case (k)
      3'd0: p = 2'b10;
      3'd1: p = 2'b11;
      3'd2: p = 2'b01;
      3'd3: p = 2'b00;
      3'd4: p = 2'b01;
      3'd5: p = 2'b11;
      3'd6: p = 2'b10;
      3'd7: p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hazard_seq_toggle_counter.sv
// Registered sampler and 2-bit saturating toggle counter for one circuit output.
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset
//   f_i     : raw circuit output
//   clr_i   : discard the current cycle's toggle and restart the count
//   f_q_o   : f_i registered once
//   count_o : toggles counted so far, including the current cycle's toggle
module hazard_seq_toggle_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       f_i,
  input  logic       clr_i,
  output logic       f_q_o,
  output logic [1:0] count_o
);

  logic       f_q;
  logic       f_qq;
  logic       toggle;
  logic [1:0] count_q;
  logic [1:0] count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_q     <= 1'b0;
      f_qq    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      f_q     <= f_i;
      f_qq    <= f_q;
      count_q <= count_d;
    end
  end

  always_comb begin
    toggle  = f_q ^ f_qq;
    count_d = count_q;
    if (clr_i) begin
      count_d = 2'd0;
    end else if (toggle && (count_q != 2'd3)) begin
      count_d = count_q + 2'd1;
    end
  end

  // Exposing the next count lets the parent evaluate a window on its last
  // cycle without losing that cycle's toggle.
  assign f_q_o   = f_q;
  assign count_o = count_d;

endmodule

// File: rtl/hazard_seq.sv
// Sequencer and checker for two-input combinational hazard circuits.
// Walks {a,b} through an 8-step single-bit-change pattern, holding each step
// for HOLD cycles, and records per-step hazards and static errors.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : run request, accepted only in idle
//   f_dut, f_ref     : circuit-under-check output and reference output
//   a, b             : registered stimulus to both circuits
//   busy, done       : run in progress / sticky completion flag
//   step             : current step index
//   hz_pulse         : one-cycle strobe after a hazardous step
//   hz_step          : step of the last hazard
//   hz_count         : saturating count of hazardous steps
//   hz_mask, err_mask: per-step hazard and static-error flags
module hazard_seq
  import hazard_seq_pkg::*;
#(
  parameter int unsigned HOLD = 16,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          f_dut,
  input  logic          f_ref,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic [2:0]    step,
  output logic          hz_pulse,
  output logic [2:0]    hz_step,
  output logic [CW-1:0] hz_count,
  output logic [7:0]    hz_mask,
  output logic [7:0]    err_mask
);

  localparam logic [7:0]    HoldLast = 8'(HOLD - 1);
  localparam logic [2:0]    LastStep = 3'(Steps - 1);
  localparam logic [CW-1:0] CountMax = {CW{1'b1}};

  state_e state_q, state_d;
  logic   run_start, step_end, run_end;

  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    ab_q, ab_d;
  logic          done_q, done_d;
  logic          hz_pulse_q, hz_pulse_d;
  logic [2:0]    hz_step_q, hz_step_d;
  logic [CW-1:0] hz_count_q, hz_count_d;
  logic [7:0]    hz_mask_q, hz_mask_d;
  logic [7:0]    err_mask_q, err_mask_d;

  logic       f_q, r_q;
  logic       tog_clr;
  logic [1:0] tog_count;
  logic       hazard, static_err;

  // A toggle seen at cnt=0 comes from the previous step's tail; clearing on
  // that cycle drops it.
  assign tog_clr = (cnt_q == 8'd0);

  hazard_seq_toggle_counter u_tog (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .f_i     (f_dut),
    .clr_i   (tog_clr),
    .f_q_o   (f_q),
    .count_o (tog_count)
  );

  assign hazard     = tog_count[1];
  assign static_err = f_q ^ r_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)   state_d = StRun;
      StRun:  if (run_end) state_d = StIdle;
    endcase
  end

  // FSM outputs / control strobes
  always_comb begin
    busy      = 1'b0;
    run_start = 1'b0;
    step_end  = 1'b0;
    unique case (state_q)
      StIdle: run_start = start;
      StRun: begin
        busy     = 1'b1;
        step_end = (cnt_q == HoldLast);
      end
    endcase
    run_end = step_end && (step_q == LastStep);
  end

  // Counters, stimulus and result registers
  always_comb begin
    cnt_d      = cnt_q;
    step_d     = step_q;
    ab_d       = ab_q;
    done_d     = done_q;
    hz_pulse_d = 1'b0;
    hz_step_d  = hz_step_q;
    hz_count_d = hz_count_q;
    hz_mask_d  = hz_mask_q;
    err_mask_d = err_mask_q;

    if (run_start) begin
      cnt_d      = 8'd0;
      step_d     = 3'd0;
      ab_d       = step_pattern(3'd0);
      done_d     = 1'b0;
      hz_step_d  = 3'd0;
      hz_count_d = '0;
      hz_mask_d  = 8'h00;
      err_mask_d = 8'h00;
    end else if (busy) begin
      if (step_end) begin
        cnt_d      = 8'd0;
        hz_pulse_d = hazard;
        if (hazard) begin
          hz_mask_d[step_q] = 1'b1;
          hz_step_d         = step_q;
          if (hz_count_q != CountMax) begin
            hz_count_d = hz_count_q + 1'b1;
          end
        end
        if (static_err) begin
          err_mask_d[step_q] = 1'b1;
        end
        if (run_end) begin
          step_d = 3'd0;
          ab_d   = 2'b00;
          done_d = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
          ab_d   = step_pattern(step_q + 3'd1);
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= 8'd0;
      step_q     <= 3'd0;
      ab_q       <= 2'b00;
      done_q     <= 1'b0;
      hz_pulse_q <= 1'b0;
      hz_step_q  <= 3'd0;
      hz_count_q <= '0;
      hz_mask_q  <= 8'h00;
      err_mask_q <= 8'h00;
      r_q        <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      ab_q       <= ab_d;
      done_q     <= done_d;
      hz_pulse_q <= hz_pulse_d;
      hz_step_q  <= hz_step_d;
      hz_count_q <= hz_count_d;
      hz_mask_q  <= hz_mask_d;
      err_mask_q <= err_mask_d;
      r_q        <= f_ref;
    end
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign step     = step_q;
  assign done     = done_q;
  assign hz_pulse = hz_pulse_q;
  assign hz_step  = hz_step_q;
  assign hz_count = hz_count_q;
  assign hz_mask  = hz_mask_q;
  assign err_mask = err_mask_q;

endmodule

// File: tb/tb_hazard_seq.sv
// Scoreboard bench for hazard_seq. The bench plays both circuits: f_ref and
// f_dut are truth tables of {a,b}, with f_dut optionally inverted for chosen
// cycles to inject glitches. Each accepted run pushes a step-level prediction
// into a queue; a monitor on the falling edge checks the live outputs and
// pops the prediction when done appears.
module tb_hazard_seq;

  localparam int H  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          f_dut, f_ref;
  logic          a, b, busy, done, hz_pulse;
  logic [2:0]    step, hz_step;
  logic [CW-1:0] hz_count;
  logic [7:0]    hz_mask, err_mask;

  logic [3:0] dut_tt = 4'h0;
  logic [3:0] ref_tt = 4'h0;
  logic       inv = 1'b0;

  assign f_dut = dut_tt[{a, b}] ^ inv;
  assign f_ref = ref_tt[{a, b}];

  hazard_seq #(.HOLD(H), .CW(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .f_dut    (f_dut),
    .f_ref    (f_ref),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .step     (step),
    .hz_pulse (hz_pulse),
    .hz_step  (hz_step),
    .hz_count (hz_count),
    .hz_mask  (hz_mask),
    .err_mask (err_mask)
  );

  typedef struct {
    int         n0;
    logic [7:0] hz_mask;
    logic [7:0] err_mask;
    int         hz_count;
    logic [2:0] hz_step;
  } rec_t;

  rec_t rec_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pat_of(input int k);
    case (k)
      0: return 2'b10;
      1: return 2'b11;
      2: return 2'b01;
      3: return 2'b00;
      4: return 2'b01;
      5: return 2'b11;
      6: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Step-level prediction: a clean change of f_dut gives one toggle, each
  // injected pulse two, and a tail pulse one (its trailing edge lands in the
  // next step's discarded first cycle). A tail also leaves the settled value
  // inverted at the evaluation point.
  function automatic rec_t model(input logic [3:0] dtt, input logic [3:0] rtt,
                                 input logic [15:0] gv, input logic [7:0] tv, input int n0);
    rec_t       r;
    logic       prev;
    logic [1:0] p;
    int         tog, n, max_cnt;
    r.n0 = n0; r.hz_mask = 8'h00; r.err_mask = 8'h00; r.hz_step = 3'd0;
    n = 0;
    max_cnt = (1 << CW) - 1;
    prev = dtt[0];
    for (int k = 0; k < 8; k++) begin
      p = pat_of(k);
      tog = int'(dtt[p] != prev) + 2 * int'(gv[2*k +: 2]) + int'(tv[k]);
      if (tog >= 2) begin
        r.hz_mask[k] = 1'b1;
        r.hz_step = 3'(k);
        n++;
      end
      if ((dtt[p] ^ tv[k]) != rtt[p]) r.err_mask[k] = 1'b1;
      prev = dtt[p];
    end
    r.hz_count = (n > max_cnt) ? max_cnt : n;
    return r;
  endfunction

  // Inversion of f_dut during run cycle e: g two-cycle pulses from cycle 2,
  // and an optional tail covering the last few cycles except the final one.
  function automatic logic inv_at(input int e, input logic [15:0] gv, input logic [7:0] tv);
    int k, c, g;
    k = e / H;
    c = e % H;
    g = int'(gv[2*k +: 2]);
    return ((c >= 2) && (c < 2 + 4*g) && (((c - 2) % 4) < 2)) ||
           (tv[k] && (c >= H - 4) && (c < H - 1));
  endfunction

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, 32'(a), 32'd0);
    chk({tag, "_b"}, 32'(b), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_hz_pulse"}, 32'(hz_pulse), 32'd0);
    chk({tag, "_hz_step"}, 32'(hz_step), 32'd0);
    chk({tag, "_hz_count"}, 32'(hz_count), 32'd0);
    chk({tag, "_hz_mask"}, 32'(hz_mask), 32'd0);
    chk({tag, "_err_mask"}, 32'(err_mask), 32'd0);
  endtask

  // Called at #1 after a rising edge, in idle (or in the done cycle when the
  // previous run held start high). keep leaves start high for a following run.
  task automatic do_run(input logic [3:0] dtt, input logic [3:0] rtt, input logic [15:0] gv,
                        input logic [7:0] tv, input int abort_at, input bit keep);
    dut_tt = dtt;
    ref_tt = rtt;
    start  = 1'b1;
    rec_q.push_back(model(dtt, rtt, gv, tv, cyc + 1));
    wait_edge();
    for (int e = 0; e < 8*H; e++) begin
      inv = inv_at(e, gv, tv);
      if (e == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        rec_q.delete();
        inv = 1'b0;
        start = 1'b0;
        wait_edge();
        wait_edge();
        reset_n = 1'b1;
        wait_edge();
        return;
      end
      // Random start pulses while busy must have no effect.
      start = keep ? 1'b1 : 1'(($urandom & 3) == 0);
      wait_edge();
    end
    inv   = 1'b0;
    start = keep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) wait_edge();
  endtask

  // Monitor / scoreboard
  rec_t mr;
  int   me;
  logic mp;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rec_q.size() == 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hz_pulse", 32'(hz_pulse), 32'd0);
      end else begin
        mr = rec_q[0];
        me = cyc - mr.n0;
        if (me < 0) begin
          chk("pre_start_busy", 32'(busy), 32'd0);
        end else begin
          mp = 1'b0;
          if ((me % H == 0) && (me >= H)) mp = mr.hz_mask[me/H - 1];
          chk("hz_pulse", 32'(hz_pulse), 32'(mp));
          if (mp) chk("hz_step_at_pulse", 32'(hz_step), 32'(me/H - 1));
          if (me < 8*H) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_step", 32'(step), 32'(me/H));
            chk("run_ab", 32'({a, b}), 32'(pat_of(me/H)));
          end
          if (me == 0) begin
            chk("start_done_clr", 32'(done), 32'd0);
            chk("start_hz_mask_clr", 32'(hz_mask), 32'd0);
            chk("start_err_mask_clr", 32'(err_mask), 32'd0);
            chk("start_hz_count_clr", 32'(hz_count), 32'd0);
            chk("start_hz_step_clr", 32'(hz_step), 32'd0);
          end
          if (me == 8*H) begin
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_done", 32'(done), 32'd1);
            chk("end_ab", 32'({a, b}), 32'd0);
            chk("end_step", 32'(step), 32'd0);
            chk("end_hz_count", 32'(hz_count), 32'(mr.hz_count));
            chk("end_hz_mask", 32'(hz_mask), 32'(mr.hz_mask));
            chk("end_err_mask", 32'(err_mask), 32'(mr.err_mask));
            chk("end_hz_step", 32'(hz_step), 32'(mr.hz_step));
            void'(rec_q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus
  localparam logic [3:0] TtOr  = 4'b1110;
  localparam logic [3:0] TtAnd = 4'b1000;

  initial begin
    logic [3:0]  dtt, rtt;
    logic [15:0] gv;
    logic [7:0]  tv;

    #3;
    reset_n = 1'b0;
    #1;
    check_zero("reset");
    wait_edge();
    wait_edge();
    reset_n = 1'b1;
    idle(3);

    // Hazard-free: f_dut = f_ref = a|b.
    do_run(TtOr, TtOr, 16'h0000, 8'h00, -1, 1'b0);
    idle(4);
    // Single 1->0->1 glitch after a falls with b=1 (step 2).
    do_run(TtOr, TtOr, 16'h0010, 8'h00, -1, 1'b0);
    idle(4);
    // Stuck-at-0 against a&b: errors at steps 1 and 5.
    do_run(4'b0000, TtAnd, 16'h0000, 8'h00, -1, 1'b0);
    idle(4);
    // Glitch in every step: hz_count saturates.
    do_run(TtOr, TtOr, 16'h5555, 8'h00, -1, 1'b0);
    idle(4);
    // Tail pulses whose trailing edge crosses into the next step.
    do_run(TtOr, TtOr, 16'h0000, 8'h81, -1, 1'b0);
    idle(4);
    // Reset mid-run in step 4, then a clean full run.
    do_run(TtOr, TtOr, 16'h0404, 8'h00, 4*H + 3, 1'b0);
    idle(2);
    do_run(TtOr, TtOr, 16'h0000, 8'h00, -1, 1'b0);
    idle(4);
    // Back-to-back with start held high; second run must clear first's results.
    do_run(TtOr, TtAnd, 16'h5555, 8'h00, -1, 1'b1);
    do_run(TtAnd, TtAnd, 16'h0000, 8'h00, -1, 1'b0);
    idle(4);

    for (int r = 0; r < 6; r++) begin
      dtt = 4'($urandom);
      rtt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : dtt;
      gv  = 16'h0000;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) gv[2*k +: 2] = 2'($urandom_range(1, 2));
      end
      tv = 8'($urandom) & 8'($urandom);
      do_run(dtt, rtt, gv, tv, -1, 1'b0);
      idle(1 + $urandom_range(0, 3));
    end

    idle(2);
    chk("runs_pending", 32'(rec_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
